// File: rtl/input_conditioner_pkg.sv
// Shared constants and sizing helpers for the input conditioner.
//
// Contents:
//   DEFAULT_*      default board clock, debounce tick rate and I/O counts
//   tick_period()  clock cycles per debounce sample tick
//   count_width()  bits needed to hold the values 0..max_value (minimum 1)
package input_conditioner_pkg;

  localparam int DEFAULT_CLK_HZ       = 100_000_000;
  localparam int DEFAULT_TICK_HZ      = 1000;
  localparam int DEFAULT_STABLE_TICKS = 5;
  localparam int DEFAULT_NUM_SW       = 16;
  localparam int DEFAULT_NUM_BTN      = 4;
  localparam int DEFAULT_RST_STRETCH  = 16;

  function automatic int tick_period(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

  // A zero-width counter is never useful, so the result is clamped to 1 bit.
  function automatic int count_width(input int max_value);
    return (max_value < 1) ? 1 : $clog2(max_value + 1);
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// One conditioned input bit: 2-flop synchroniser, tick-driven stability
// counter and the debounced (clean) level.
//
// Ports:
//   clk    system clock
//   rst    asynchronous active-high reset
//   tick   one-cycle debounce sample strobe, shared by all bits
//   raw    asynchronous input level
//   clean  debounced level
//
// The clean level flips only after the synchronised level has disagreed with
// it on STABLE_TICKS consecutive ticks. Any single cycle of agreement clears
// the count, so a bounce shorter than one tick period can never be accepted.
module debounce_bit
  import input_conditioner_pkg::*;
#(
  parameter int STABLE_TICKS = DEFAULT_STABLE_TICKS
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic raw,
  output logic clean
);

  localparam int              KW     = count_width(STABLE_TICKS);
  localparam logic [KW-1:0]   K_LAST = KW'(STABLE_TICKS - 1);

  logic          sync_meta;
  logic          sync_out;
  logic [KW-1:0] k;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_meta <= 1'b0;
      sync_out  <= 1'b0;
      k         <= '0;
      clean     <= 1'b0;
    end else begin
      sync_meta <= raw;
      sync_out  <= sync_meta;
      if (sync_out == clean) begin
        k <= '0;
      end else if (tick) begin
        if (k == K_LAST) begin
          clean <= sync_out;
          k     <= '0;
        end else begin
          k <= k + KW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/input_conditioner.sv
// Front end for the board top: conditions raw slide switches and push buttons
// and generates a stretched active-low reset for the user design.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset
//   sw_raw     asynchronous switch levels
//   btn_raw    asynchronous button levels, 1 = pressed (btn 0 is the reset button)
//   sw_clean   debounced switch levels
//   btn_clean  debounced button levels
//   btn_rise   one-cycle pulse, the cycle after btn_clean goes 0->1
//   btn_fall   one-cycle pulse, the cycle after btn_clean goes 1->0
//   sys_rst_n  active-low downstream reset, deasserted synchronously
//   tick       one-cycle debounce sample strobe
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int CLK_HZ       = DEFAULT_CLK_HZ,
  parameter int TICK_HZ      = DEFAULT_TICK_HZ,
  parameter int STABLE_TICKS = DEFAULT_STABLE_TICKS,
  parameter int NUM_SW       = DEFAULT_NUM_SW,
  parameter int NUM_BTN      = DEFAULT_NUM_BTN,
  parameter int RST_STRETCH  = DEFAULT_RST_STRETCH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SW-1:0]  sw_raw,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_SW-1:0]  sw_clean,
  output logic [NUM_BTN-1:0] btn_clean,
  output logic [NUM_BTN-1:0] btn_rise,
  output logic [NUM_BTN-1:0] btn_fall,
  output logic               sys_rst_n,
  output logic               tick
);

  localparam int NB = NUM_SW + NUM_BTN;
  localparam int P  = tick_period(CLK_HZ, TICK_HZ);
  localparam int PW = count_width(P - 1);
  localparam int SW = count_width(RST_STRETCH);

  localparam logic [PW-1:0] P_LAST       = PW'(P - 1);
  localparam logic [SW-1:0] STRETCH_LOAD = SW'(RST_STRETCH);

  // Parameter sanity, caught at elaboration.
  if (CLK_HZ % TICK_HZ != 0) begin : g_chk_div
    $error("input_conditioner: CLK_HZ must be divisible by TICK_HZ");
  end
  if (STABLE_TICKS < 1) begin : g_chk_stable
    $error("input_conditioner: STABLE_TICKS must be at least 1");
  end
  if (NUM_BTN < 1) begin : g_chk_btn
    $error("input_conditioner: NUM_BTN must be at least 1");
  end
  if (RST_STRETCH < 1) begin : g_chk_stretch
    $error("input_conditioner: RST_STRETCH must be at least 1");
  end

  // ---------------------------------------------------------------------------
  // Prescaler. 'running' keeps tick low while in reset even when P == 1,
  // where the count is permanently at its last value.
  // ---------------------------------------------------------------------------
  logic [PW-1:0] pcnt;
  logic          running;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt    <= '0;
      running <= 1'b0;
    end else begin
      running <= 1'b1;
      pcnt    <= (pcnt == P_LAST) ? '0 : pcnt + PW'(1);
    end
  end

  assign tick = running & (pcnt == P_LAST);

  // ---------------------------------------------------------------------------
  // Per-bit synchronise + debounce. Switches occupy the low bits.
  // ---------------------------------------------------------------------------
  logic [NB-1:0] raw_all;
  logic [NB-1:0] clean_all;

  assign raw_all = {btn_raw, sw_raw};

  for (genvar g = 0; g < NB; g++) begin : g_bit
    debounce_bit #(
      .STABLE_TICKS(STABLE_TICKS)
    ) u_debounce (
      .clk  (clk),
      .rst  (rst),
      .tick (tick),
      .raw  (raw_all[g]),
      .clean(clean_all[g])
    );
  end

  assign sw_clean  = clean_all[NUM_SW-1:0];
  assign btn_clean = clean_all[NB-1:NUM_SW];

  // ---------------------------------------------------------------------------
  // Button edge pulses, registered one cycle behind btn_clean.
  // ---------------------------------------------------------------------------
  logic [NUM_BTN-1:0] btn_clean_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_clean_d <= '0;
      btn_rise    <= '0;
      btn_fall    <= '0;
    end else begin
      btn_clean_d <= btn_clean;
      btn_rise    <= btn_clean & ~btn_clean_d;
      btn_fall    <= ~btn_clean & btn_clean_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Reset stretcher. Assertion is immediate (async rst) or one cycle after
  // btn_clean[0]; release happens only after the counter has drained, from a
  // flop, so the downstream reset never glitches.
  // ---------------------------------------------------------------------------
  logic [SW-1:0] stretch_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stretch_cnt <= STRETCH_LOAD;
      sys_rst_n   <= 1'b0;
    end else if (btn_clean[0]) begin
      stretch_cnt <= STRETCH_LOAD;
      sys_rst_n   <= 1'b0;
    end else if (stretch_cnt != '0) begin
      stretch_cnt <= stretch_cnt - SW'(1);
      sys_rst_n   <= 1'b0;
    end else begin
      sys_rst_n   <= 1'b1;
    end
  end

endmodule
